// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier, one partial product per clock, with signed/unsigned
// mode and valid/ready handshakes on operand input and product output.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]           state_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [2*WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mult_r;
  logic [WIDTH-1:0]     acc_r;
  logic                 neg_r;
  logic [CW-1:0]        cnt_r;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   result_s;

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      magnitude = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = x;
    end
  endfunction

  // Add/shift step and the final signed product, computed from the current chain state.
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (mult_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s  = {1'b0, acc_r} + {1'b0, addend_s};
    prod_s = {sum_s, mult_r[WIDTH-1:1]};
    if (neg_r) begin
      result_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_s = prod_s;
    end
  end

  // Control FSM and datapath registers; in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      p_r         <= {(2*WIDTH){1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      mult_r      <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      neg_r       <= 1'b0;
      cnt_r       <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid && in_ready_r) begin
            mcand_r    <= magnitude(a, signed_mode);
            mult_r     <= magnitude(b, signed_mode);
            neg_r      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= CALC;
          end
        end
        CALC: begin
          acc_r  <= sum_s[WIDTH:1];
          mult_r <= {sum_s[0], mult_r[WIDTH-1:1]};
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            p_r         <= result_s;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign p         = p_r;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: one 4-bit and one 8-bit instance on a shared clock/reset,
// hand-computed products, latency, backpressure, operand isolation and async reset.
module tb_seq_mult_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       iv4 = 1'b0, ir4, sm4 = 1'b0, ov4, or4 = 1'b1, busy4;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic [7:0] p4;

  logic        iv8 = 1'b0, ir8, sm8 = 1'b0, ov8, or8 = 1'b1, busy8;
  logic [7:0]  a8 = 8'h0, b8 = 8'h0;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  seq_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation on the selected instance and check busy, latency, product and handshake.
  task automatic do_op(input bit w8, input logic [7:0] av, input logic [7:0] bv, input logic sm,
                       input logic [15:0] exp, input bit scr, input bit hs, input string tag);
    int k;
    int wl;
    logic rdy;
    logic ov;
    wl = w8 ? 8 : 4;
    k = 0;
    rdy = w8 ? ir8 : ir4;
    while (!rdy && k < 20) begin
      @(negedge clk);
      k++;
      rdy = w8 ? ir8 : ir4;
    end
    if (!rdy) begin
      check_eq({tag, "_rdy"}, 32'(rdy), 32'd1);
      return;
    end
    if (w8) begin
      iv8 = 1'b1; a8 = av; b8 = bv; sm8 = sm;
    end else begin
      iv4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; sm4 = sm;
    end
    @(negedge clk);
    iv4 = 1'b0;
    iv8 = 1'b0;
    check_eq({tag, "_busy"}, 32'(w8 ? busy8 : busy4), 32'd1);
    k = 0;
    ov = 1'b0;
    while (!ov && k < 40) begin
      if (scr) begin
        if (w8) begin
          a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm8;
        end else begin
          a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~sm4;
        end
      end
      @(negedge clk);
      k++;
      ov = w8 ? ov8 : ov4;
    end
    check_eq({tag, "_lat"}, 32'(k), 32'(wl));
    check_eq({tag, "_p"}, 32'(w8 ? p8 : {8'h00, p4}), 32'(exp));
    if (hs) begin
      @(negedge clk);
      check_eq({tag, "_ovlo"}, 32'(w8 ? ov8 : ov4), 32'd0);
      check_eq({tag, "_rdyhi"}, 32'(w8 ? ir8 : ir4), 32'd1);
    end
  endtask

  initial begin
    #2;
    check_eq("rst_ready", 32'(ir4), 32'd0);
    check_eq("rst_ovalid", 32'(ov4), 32'd0);
    check_eq("rst_busy", 32'(busy4), 32'd0);
    check_eq("rst_p", 32'(p8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready4", 32'(ir4), 32'd1);
    check_eq("post_rst_ready8", 32'(ir8), 32'd1);

    do_op(1'b0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 1'b0, 1'b1, "u4_ff");
    do_op(1'b0, 8'h08, 8'h08, 1'b1, 16'h0040, 1'b0, 1'b1, "s4_m8m8");
    do_op(1'b0, 8'h08, 8'h07, 1'b1, 16'h00C8, 1'b0, 1'b1, "s4_m8p7");
    do_op(1'b1, 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 1'b1, "s8_m3p5");
    do_op(1'b1, 8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b0, 1'b1, "u8_fd05");
    do_op(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 1'b1, "s8_min");
    do_op(1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b1, "u8_max");
    do_op(1'b1, 8'h00, 8'hFF, 1'b1, 16'h0000, 1'b0, 1'b1, "s8_zero");
    do_op(1'b1, 8'h12, 8'h0B, 1'b0, 16'h00C6, 1'b1, 1'b1, "u8_scramble");

    // Backpressure: result must hold while the consumer stalls, and no new operands are taken.
    or4 = 1'b0;
    do_op(1'b0, 8'h03, 8'h05, 1'b0, 16'h000F, 1'b0, 1'b0, "bp");
    iv4 = 1'b1; a4 = 4'h9; b4 = 4'h9; sm4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_ov", 32'(ov4), 32'd1);
      check_eq("bp_p", 32'(p4), 32'h0F);
      check_eq("bp_ready", 32'(ir4), 32'd0);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_ov", 32'(ov4), 32'd0);
    check_eq("bp_rel_ready", 32'(ir4), 32'd1);
    check_eq("bp_rel_p", 32'(p4), 32'h0F);

    // Asynchronous reset during the second CALC cycle.
    iv4 = 1'b1; a4 = 4'h7; b4 = 4'h7; sm4 = 1'b0;
    @(negedge clk);
    iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy4), 32'd0);
    check_eq("arst_ov", 32'(ov4), 32'd0);
    check_eq("arst_ready", 32'(ir4), 32'd0);
    check_eq("arst_p", 32'(p4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_rel_ready", 32'(ir4), 32'd1);
    check_eq("arst_rel_ov", 32'(ov4), 32'd0);
    do_op(1'b0, 8'h03, 8'h05, 1'b0, 16'h000F, 1'b0, 1'b1, "arst_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
